// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FL_STALL = 2'd2,
    BR_FLUSH = 2'd3
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EX hazard-observation and pipeline-control bundle.
// slave: the hazard sequencer; master: the pipeline datapath.
interface pipe_hazard_ctrl_if;
  import hazard_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic             id_rn_used;
  logic [REG_W-1:0] id_rm;
  logic             id_rm_used;
  logic             id_flag_use;
  logic             ex_valid;
  logic             ex_memRead;
  logic [REG_W-1:0] ex_rd;
  logic             ex_set_flags;
  logic             br_taken_ex;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [1:0]       hz_state;
  logic [31:0]      stall_cnt;
  logic [31:0]      flush_cnt;

  modport slave (
    input  id_valid, id_rn, id_rn_used, id_rm, id_rm_used, id_flag_use,
    input  ex_valid, ex_memRead, ex_rd, ex_set_flags, br_taken_ex,
    output pc_en, ifid_en, ifid_flush, idex_bubble, hz_state,
    output stall_cnt, flush_cnt
  );

  modport master (
    output id_valid, id_rn, id_rn_used, id_rm, id_rm_used, id_flag_use,
    output ex_valid, ex_memRead, ex_rd, ex_set_flags, br_taken_ex,
    input  pc_en, ifid_en, ifid_flush, idex_bubble, hz_state,
    input  stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_reg_match.sv
// Compares one ID source register against the EX destination; XZR never matches.
module hazard_reg_match
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] srcReg,
  input  logic             srcUsed,
  input  logic [REG_W-1:0] exRd,
  output logic             match
);

  assign match = srcUsed && (srcReg == exRd) && (exRd != XZR);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use / flag stalls and taken-branch flushes.
// Define HAZ_PERF_CNT_EN to build the stall/flush performance counters.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned FLAG_LAT    = 1,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 2
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz
);

  hz_state_t        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             rnMatch, rmMatch;
  logic             loadUse, flagHaz, brTake;
  logic             pcEn, ifidEn, ifidFlush, idexBubble;

  hazard_reg_match uRnMatch (
    .srcReg (hz.id_rn),
    .srcUsed(hz.id_rn_used),
    .exRd   (hz.ex_rd),
    .match  (rnMatch)
  );

  hazard_reg_match uRmMatch (
    .srcReg (hz.id_rm),
    .srcUsed(hz.id_rm_used),
    .exRd   (hz.ex_rd),
    .match  (rmMatch)
  );

  assign loadUse = hz.ex_valid && hz.ex_memRead && hz.id_valid && (rnMatch || rmMatch);
  assign flagHaz = hz.ex_valid && hz.ex_set_flags && hz.id_valid && hz.id_flag_use;
  // A branch is honoured in every state except BR_FLUSH, including the stall
  // states where it is a protocol violation but still wins over the stall.
  assign brTake  = hz.br_taken_ex && (state != BR_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    if (brTake) begin
      if (FLUSH_DEPTH > 1) begin
        stateNext = BR_FLUSH;
        cntNext   = CNT_W'(FLUSH_DEPTH - 1);
      end else begin
        stateNext = RUN;
        cntNext   = '0;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (loadUse) begin
            if (LOAD_LAT > 1) begin
              stateNext = LU_STALL;
              cntNext   = CNT_W'(LOAD_LAT - 1);
            end
          end else if (flagHaz) begin
            if (FLAG_LAT > 1) begin
              stateNext = FL_STALL;
              cntNext   = CNT_W'(FLAG_LAT - 1);
            end
          end
        end
        LU_STALL, FL_STALL, BR_FLUSH: begin
          cntNext = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) stateNext = RUN;
        end
        default: begin
          stateNext = RUN;
          cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pcEn       = 1'b1;
    ifidEn     = 1'b1;
    ifidFlush  = 1'b0;
    idexBubble = 1'b0;
    if (rst) begin
      pcEn       = 1'b0;
      ifidEn     = 1'b0;
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (brTake || state == BR_FLUSH) begin
      ifidFlush  = 1'b1;
      idexBubble = 1'b1;
    end else if (state == LU_STALL || state == FL_STALL ||
                 (state == RUN && (loadUse || flagHaz))) begin
      pcEn       = 1'b0;
      ifidEn     = 1'b0;
      idexBubble = 1'b1;
    end
  end

  assign hz.pc_en       = pcEn;
  assign hz.ifid_en     = ifidEn;
  assign hz.ifid_flush  = ifidFlush;
  assign hz.idex_bubble = idexBubble;
  assign hz.hz_state    = state;

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stallCnt, flushCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcEn)  stallCnt <= stallCnt + 32'd1;
      if (brTake) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign hz.stall_cnt = stallCnt;
  assign hz.flush_cnt = flushCnt;
`else
  assign hz.stall_cnt = '0;
  assign hz.flush_cnt = '0;
`endif

endmodule
